axis_ecg_derivative: RTL and testbench
======================================

Name: axis_ecg_derivative

Overview:
- AXI-Stream derivative filter for the ECG QRS-detection chain, between the band-pass stage and the squaring/integration stage.
- Parametrised in data width and derivative kernel: simple first difference, or Pan-Tompkins 5-point derivative.
- Adds full downstream backpressure, frame-aware priming, output saturation and tlast passthrough.

Parameters:
DATA_W, 16, signed sample width for input and output
MODE, 0, 0 = first difference y=x[n]-x[n-1]; 1 = 5-point y=(2x[n]+x[n-1]-x[n-3]-2x[n-4])>>>3
SAT_EN, 1, 1 = saturate result to DATA_W; 0 = two's-complement wrap (truncate)
PRIME_EN, 1, 1 = suppress outputs until the delay line holds real samples

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_axis_tvalid  in  1  input sample valid
s_axis_tready  out  1  block can accept input
s_axis_tdata  in  DATA_W  signed input sample
s_axis_tlast  in  1  last sample of ECG frame
m_axis_tvalid  out  1  output sample valid
m_axis_tready  in  1  downstream accepts output
m_axis_tdata  out  DATA_W  signed derivative
m_axis_tlast  out  1  frame end, aligned with the output sample
sat_flag  out  1  sticky: some output was clipped since reset

Behaviour:
- Reset (rst=1 at clk edge): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, sat_flag=0; delay line x1..x4=0; prime counter=0.
- While rst=1, s_axis_tready=0.
- Ready rule: s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready). This is combinational, a single output register with no skid buffer.
- Accept = s_axis_tvalid && s_axis_tready.
- Delay line shifts only on accept: x1<=x[n]; x2<=x1; x3<=x2; x4<=x3. MODE 0 uses only x1.
- Latency: one cycle from accept to m_axis_tvalid=1.
- Output hold: data and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Arithmetic, MODE 0: computed at DATA_W+1 bits.
- Arithmetic, MODE 1: computed at DATA_W+3 bits, then arithmetic shift right by 3 (floor toward -inf).
- Narrowing to DATA_W, SAT_EN=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Set sat_flag when a clamp occurs on a sample that is actually emitted.
- Narrowing to DATA_W, SAT_EN=0: keep the low DATA_W bits; sat_flag stays 0.
- Priming: TAPS = 1 (MODE 0) or 4 (MODE 1). With PRIME_EN=1, the first TAPS accepts after reset or after a frame boundary update the delay line but emit nothing. Prime counter saturates at TAPS. With PRIME_EN=0, zeros in the delay line are used.
- Frame boundary: accept with s_axis_tlast=1:
  - if the beat is emitted, m_axis_tlast=1 on that output;
  - on the next cycle, x1..x4 and the prime counter clear to 0, so the next frame re-primes.
  - If the tlast beat itself is suppressed by priming, nothing is emitted and the clear still occurs.
- Simultaneous output drain and new accept: the output register reloads and m_axis_tvalid stays 1 with no bubble.
- Accept of a suppressed (priming) beat while the output drains: m_axis_tvalid falls to 0.
- Reset mid-stream: the pending output is dropped and state returns to reset values on that edge; no output appears until re-primed.

Decomposition:
- Shared ecg_pkg: MODE encodings (DIFF_FIRST=0, DIFF_PT5=1), TAPS per mode, saturation helper function sat_narrow(value, width).
- One natural sub-module, ecg_sat_narrow: combinational clamp/wrap with an overflow indicator.
- Delay line, prime counter and handshake stay in the top module.

Test Plan:
1. MODE0, PRIME_EN=1, m_axis_tready=1; inputs 0,100,200,300 -> first input suppressed; outputs 100,100,100 each one cycle after accept; sat_flag=0.
2. MODE0, SAT_EN=1; inputs 0,32767,-32768,32767 -> outputs 32767, -32768 (sat), 32767 (sat); sat_flag=1 from the first clipped output onward.
3. MODE1; inputs 0,0,0,0,80,0,0,0,0 -> first four suppressed; outputs 20,10,0,-10,-20.
4. Backpressure, MODE0: stream 10,20,30,40 continuously, m_axis_tready=0 for 5 cycles after the first output -> s_axis_tready=0 while the output is held; no loss or duplication; outputs 10,10,10 in order after release.
5. Frame boundary, MODE1: 6 samples with tlast on the 6th, then 5 more -> 2 outputs, the second with m_axis_tlast=1; next frame suppresses its first 4 and emits 1.
6. Reset mid-stream: assert rst for 1 cycle while m_axis_tvalid=1 -> next cycle m_axis_tvalid=0, s_axis_tready=0 during rst, sat_flag=0; re-priming is observed before the next output.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared constants and helpers for the ECG derivative stage.
package ecg_pkg;
   localparam int DIFF_FIRST = 0;
   localparam int DIFF_PT5   = 1;
   localparam int TAPS_FIRST = 1;
   localparam int TAPS_PT5   = 4;
   localparam int SAT_VEC_W  = 64;

   function automatic int taps_for(input int mode);
      return (mode == DIFF_PT5) ? TAPS_PT5 : TAPS_FIRST;
   endfunction

   // Clamp a sign-extended value into the signed range of `width` bits.
   function automatic logic signed [SAT_VEC_W-1:0] sat_narrow(
      input logic signed [SAT_VEC_W-1:0] value,
      input int unsigned                 width
   );
      logic signed [SAT_VEC_W-1:0] max_v;
      logic signed [SAT_VEC_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction
endpackage

// File: rtl/ecg_sat_narrow.sv
// Narrows a wide signed result to OUT_W bits, clamping or wrapping; ovf marks out-of-range input.
module ecg_sat_narrow
   import ecg_pkg::*;
#(
   parameter int IN_W   = 19,
   parameter int OUT_W  = 16,
   parameter int SAT_EN = 1
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    ovf
);
   logic signed [SAT_VEC_W-1:0] din_ext;
   logic signed [SAT_VEC_W-1:0] clamped;

   always_comb begin
      din_ext = {{(SAT_VEC_W-IN_W){din[IN_W-1]}}, din};
      clamped = sat_narrow(din_ext, OUT_W);
      ovf     = (clamped != din_ext);
      dout    = (SAT_EN != 0) ? clamped[OUT_W-1:0] : din[OUT_W-1:0];
   end
endmodule

// File: rtl/axis_ecg_derivative.sv
// AXI-Stream derivative filter for QRS detection: first difference or 5-point
// Pan-Tompkins kernel, single output register, frame-aware priming.
module axis_ecg_derivative
   import ecg_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int MODE     = 0,
   parameter int SAT_EN   = 1,
   parameter int PRIME_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic signed [DATA_W-1:0] s_axis_tdata,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic signed [DATA_W-1:0] m_axis_tdata,
   output logic                     m_axis_tlast,
   output logic                     sat_flag
);
   localparam int         TAPS     = taps_for(MODE);
   localparam int         ACC_W    = DATA_W + 3;
   localparam logic [2:0] TAPS_CNT = 3'(TAPS);

   logic signed [DATA_W-1:0] x1, x2, x3, x4;
   logic [2:0]               prime_cnt;
   logic                     accept;
   logic                     primed;
   logic signed [ACC_W-1:0]  xn_e, x1_e, x3_e, x4_e;
   logic signed [ACC_W-1:0]  diff_first, diff_pt5, raw;
   logic signed [DATA_W-1:0] narrowed;
   logic                     clip;

   assign s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign primed        = (PRIME_EN == 0) || (prime_cnt == TAPS_CNT);

   // ACC_W is wide enough that neither kernel can overflow before narrowing.
   always_comb begin
      xn_e       = {{3{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
      x1_e       = {{3{x1[DATA_W-1]}}, x1};
      x3_e       = {{3{x3[DATA_W-1]}}, x3};
      x4_e       = {{3{x4[DATA_W-1]}}, x4};
      diff_first = xn_e - x1_e;
      diff_pt5   = ((xn_e <<< 1) + x1_e - x3_e - (x4_e <<< 1)) >>> 3;
      raw        = (MODE == DIFF_PT5) ? diff_pt5 : diff_first;
   end

   ecg_sat_narrow #(
      .IN_W   (ACC_W),
      .OUT_W  (DATA_W),
      .SAT_EN (SAT_EN)
   ) u_sat (
      .din  (raw),
      .dout (narrowed),
      .ovf  (clip)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         x1            <= '0;
         x2            <= '0;
         x3            <= '0;
         x4            <= '0;
         prime_cnt     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         sat_flag      <= 1'b0;
      end else begin
         if (accept) begin
            // A frame end empties the delay line so the next frame re-primes.
            if (s_axis_tlast) begin
               x1        <= '0;
               x2        <= '0;
               x3        <= '0;
               x4        <= '0;
               prime_cnt <= '0;
            end else begin
               x1 <= s_axis_tdata;
               x2 <= x1;
               x3 <= x2;
               x4 <= x3;
               if (prime_cnt != TAPS_CNT) prime_cnt <= prime_cnt + 3'd1;
            end
            m_axis_tvalid <= primed;
            if (primed) begin
               m_axis_tdata <= narrowed;
               m_axis_tlast <= s_axis_tlast;
               if ((SAT_EN != 0) && clip) sat_flag <= 1'b1;
            end
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axis_ecg_derivative.sv
// Self-checking bench: three configurations driven by shared stimulus, checked against
// a stream-level reference model of the derivative rules.
module tb_axis_ecg_derivative;
   localparam int W  = 16;
   localparam int ND = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                s_tvalid, s_tlast, m_tready;
   logic signed [W-1:0] s_tdata;
   logic [ND-1:0]       s_tready, m_tvalid, m_tlast, sat_flag;
   logic signed [W-1:0] m_tdata [ND];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_ecg_derivative #(.DATA_W(W), .MODE(0), .SAT_EN(1), .PRIME_EN(1)) dut0 (
      .clk(clk), .rst(rst), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .m_axis_tvalid(m_tvalid[0]),
      .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[0]), .m_axis_tlast(m_tlast[0]),
      .sat_flag(sat_flag[0]));
   axis_ecg_derivative #(.DATA_W(W), .MODE(1), .SAT_EN(1), .PRIME_EN(1)) dut1 (
      .clk(clk), .rst(rst), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .m_axis_tvalid(m_tvalid[1]),
      .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[1]), .m_axis_tlast(m_tlast[1]),
      .sat_flag(sat_flag[1]));
   axis_ecg_derivative #(.DATA_W(W), .MODE(0), .SAT_EN(0), .PRIME_EN(0)) dut2 (
      .clk(clk), .rst(rst), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[2]),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .m_axis_tvalid(m_tvalid[2]),
      .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[2]), .m_axis_tlast(m_tlast[2]),
      .sat_flag(sat_flag[2]));

   function automatic int cfg_mode(int d);  return (d == 1) ? 1 : 0; endfunction
   function automatic int cfg_sat(int d);   return (d == 2) ? 0 : 1; endfunction
   function automatic int cfg_prime(int d); return (d == 2) ? 0 : 1; endfunction

   // Reference model state: frame history, pending output, expected and observed streams.
   int hist      [ND][$];
   int pend_data [ND];
   bit pend_last [ND];
   bit occ       [ND];
   bit exp_sat   [ND];
   int exp_data  [ND][$];
   bit exp_last  [ND][$];
   int got_data  [ND][$];
   bit got_last  [ND][$];

   function automatic int floor_div8(int v);
      int q;
      q = v / 8;
      if ((v % 8) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic int narrow(int v, int sat, output bit clipped);
      int lim_hi, lim_lo, w;
      lim_hi  = 2**(W-1) - 1;
      lim_lo  = -(2**(W-1));
      clipped = 1'b0;
      if (sat != 0) begin
         if (v > lim_hi) begin clipped = 1'b1; return lim_hi; end
         if (v < lim_lo) begin clipped = 1'b1; return lim_lo; end
         return v;
      end
      w = ((v % (2**W)) + 2**W) % (2**W);
      if (w > lim_hi) w = w - 2**W;
      return w;
   endfunction

   function automatic void model_accept(int d, int x, bit last);
      int n, taps, raw, out;
      int past [1:4];
      bit clipped;
      n = hist[d].size();
      for (int k = 1; k <= 4; k++) past[k] = (k <= n) ? hist[d][n-k] : 0;
      if (cfg_mode(d) == 1) begin
         taps = 4;
         raw  = floor_div8(2*x + past[1] - past[3] - 2*past[4]);
      end else begin
         taps = 1;
         raw  = x - past[1];
      end
      if (cfg_prime(d) == 0 || n >= taps) begin
         out = narrow(raw, cfg_sat(d), clipped);
         if (clipped) exp_sat[d] = 1'b1;
         pend_data[d] = out;
         pend_last[d] = last;
         occ[d]       = 1'b1;
      end else begin
         occ[d] = 1'b0;
      end
      if (last) hist[d].delete();
      else begin
         hist[d].push_back(x);
         if (hist[d].size() > 8) void'(hist[d].pop_front());
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         for (int d = 0; d < ND; d++) begin
            bit rdy;
            if (rst) begin
               hist[d].delete();
               occ[d]     = 1'b0;
               exp_sat[d] = 1'b0;
            end else begin
               rdy = !occ[d] || m_tready;
               if (occ[d] && m_tready) begin
                  exp_data[d].push_back(pend_data[d]);
                  exp_last[d].push_back(pend_last[d]);
                  occ[d] = 1'b0;
               end
               if (s_tvalid && rdy) model_accept(d, int'(s_tdata), s_tlast);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++)
            if (!rst && m_tvalid[d] && m_tready) begin
               got_data[d].push_back(int'(m_tdata[d]));
               got_last[d].push_back(m_tlast[d]);
            end
      end
   end

   task automatic clear_streams();
      for (int d = 0; d < ND; d++) begin
         got_data[d].delete(); got_last[d].delete();
         exp_data[d].delete(); exp_last[d].delete();
      end
   endtask

   task automatic reset_all();
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_streams();
   endtask

   task automatic drive(int x, bit last);
      s_tvalid = 1'b1; s_tdata = W'(x); s_tlast = last;
      @(posedge clk);
      #1 s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_tvalid = 1'b1; s_tdata = W'(1234); s_tlast = 1'b0; m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         checks++; if (s_tready[d] !== 1'b0) begin errors++; $display("FAIL reset_tready dut%0d got %b want 0", d, s_tready[d]); end
         checks++; if (m_tvalid[d] !== 1'b0) begin errors++; $display("FAIL reset_tvalid dut%0d got %b want 0", d, m_tvalid[d]); end
         checks++; if (m_tdata[d] !== '0) begin errors++; $display("FAIL reset_tdata dut%0d got %0d want 0", d, m_tdata[d]); end
         checks++; if (m_tlast[d] !== 1'b0) begin errors++; $display("FAIL reset_tlast dut%0d got %b want 0", d, m_tlast[d]); end
         checks++; if (sat_flag[d] !== 1'b0) begin errors++; $display("FAIL reset_sat dut%0d got %b want 0", d, sat_flag[d]); end
      end
      s_tvalid = 1'b0; rst = 1'b0;
      clear_streams();
   endtask

   task automatic test_first_diff();
      int vals [4] = '{0, 100, 200, 300};
      bit vld  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      int d2_out [4] = '{0, 100, 100, 100};
      reset_all();
      for (int i = 0; i < 4; i++) begin
         drive(vals[i], 1'b0);
         checks++; if (m_tvalid[0] !== vld[i]) begin errors++; $display("FAIL diff_latency beat%0d got %b want %b", i, m_tvalid[0], vld[i]); end
         if (vld[i]) begin
            checks++; if (m_tdata[0] !== 16'sd100) begin errors++; $display("FAIL diff_data beat%0d got %0d want 100", i, m_tdata[0]); end
         end
      end
      idle(2);
      checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL diff_drain got %b want 0", m_tvalid[0]); end
      checks++; if (sat_flag[0] !== 1'b0) begin errors++; $display("FAIL diff_sat got %b want 0", sat_flag[0]); end
      checks++; if (got_data[0].size() != 3) begin errors++; $display("FAIL diff_count got %0d want 3", got_data[0].size()); end
      checks++; if (got_data[1].size() != 0) begin errors++; $display("FAIL pt5_primed_count got %0d want 0", got_data[1].size()); end
      checks++; if (got_data[2].size() != 4) begin errors++; $display("FAIL noprime_count got %0d want 4", got_data[2].size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (got_data[2][i] != d2_out[i]) begin errors++; $display("FAIL noprime_data beat%0d got %0d want %0d", i, got_data[2][i], d2_out[i]); end
      end
   endtask

   task automatic test_saturation();
      int vals [4] = '{0, 32767, -32768, 32767};
      int outs [4] = '{0, 32767, -32768, 32767};
      bit sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int wrap [4] = '{0, 32767, 1, -1};
      reset_all();
      for (int i = 0; i < 4; i++) begin
         drive(vals[i], 1'b0);
         checks++; if (sat_flag[0] !== sat[i]) begin errors++; $display("FAIL sat_flag beat%0d got %b want %b", i, sat_flag[0], sat[i]); end
         if (i > 0) begin
            checks++; if (m_tdata[0] !== W'(outs[i])) begin errors++; $display("FAIL sat_data beat%0d got %0d want %0d", i, m_tdata[0], outs[i]); end
         end
      end
      idle(2);
      checks++; if (sat_flag[2] !== 1'b0) begin errors++; $display("FAIL wrap_sat got %b want 0", sat_flag[2]); end
      checks++; if (got_data[2].size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got_data[2].size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (got_data[2][i] != wrap[i]) begin errors++; $display("FAIL wrap_data beat%0d got %0d want %0d", i, got_data[2][i], wrap[i]); end
      end
   endtask

   task automatic test_pt5();
      int vals [9] = '{0, 0, 0, 0, 80, 0, 0, 0, 0};
      int outs [5] = '{20, 10, 0, -10, -20};
      reset_all();
      for (int i = 0; i < 9; i++) drive(vals[i], 1'b0);
      idle(2);
      checks++; if (got_data[1].size() != 5) begin errors++; $display("FAIL pt5_count got %0d want 5", got_data[1].size()); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (got_data[1][i] != outs[i]) begin errors++; $display("FAIL pt5_data beat%0d got %0d want %0d", i, got_data[1][i], outs[i]); end
      end
   endtask

   task automatic test_backpressure();
      int vals [4] = '{10, 20, 30, 40};
      int idx = 0, cyc = 0, stall = 0;
      bit seen = 1'b0, acc;
      reset_all();
      s_tvalid = 1'b1; s_tdata = W'(vals[0]);
      while (idx < 4 && cyc < 60) begin
         @(negedge clk);
         if (stall > 0) begin
            checks++; if (s_tready[0] !== 1'b0) begin errors++; $display("FAIL bp_tready got %b want 0", s_tready[0]); end
            checks++; if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 16'sd10) begin errors++; $display("FAIL bp_hold got v=%b d=%0d want v=1 d=10", m_tvalid[0], m_tdata[0]); end
         end
         acc = s_tvalid && (!occ[0] || m_tready);
         @(posedge clk);
         #1 cyc++;
         if (acc) begin
            idx++;
            if (idx < 4) s_tdata = W'(vals[idx]); else s_tvalid = 1'b0;
         end
         if (stall > 0) begin
            stall--;
            if (stall == 0) m_tready = 1'b1;
         end else if (!seen && occ[0]) begin
            seen = 1'b1; m_tready = 1'b0; stall = 5;
         end
      end
      checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout accepted %0d want 4", idx); end
      s_tvalid = 1'b0; m_tready = 1'b1;
      idle(3);
      checks++; if (got_data[0].size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_data[0].size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (got_data[0][i] != 10) begin errors++; $display("FAIL bp_data beat%0d got %0d want 10", i, got_data[0][i]); end
      end
   endtask

   task automatic test_frame();
      bit lasts [3] = '{1'b0, 1'b1, 1'b0};
      reset_all();
      for (int i = 1; i <= 6; i++) begin
         drive(8*i, i == 6);
         if (i == 6) begin
            checks++; if (m_tvalid[1] !== 1'b1 || m_tlast[1] !== 1'b1) begin errors++; $display("FAIL frame_tlast got v=%b l=%b want 1 1", m_tvalid[1], m_tlast[1]); end
         end
      end
      for (int i = 1; i <= 5; i++) drive(8*i, 1'b0);
      idle(3);
      checks++; if (got_data[1].size() != 3) begin errors++; $display("FAIL frame_count got %0d want 3", got_data[1].size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (got_data[1][i] != 10 || got_last[1][i] != lasts[i]) begin errors++; $display("FAIL frame_beat%0d got d=%0d l=%b want d=10 l=%b", i, got_data[1][i], got_last[1][i], lasts[i]); end
      end
      checks++; if (got_data[0].size() != 9) begin errors++; $display("FAIL frame_diff_count got %0d want 9", got_data[0].size()); end
   endtask

   task automatic test_reset_mid();
      reset_all();
      drive(0, 1'b0); drive(32767, 1'b0); drive(-32768, 1'b0);
      m_tready = 1'b0;
      checks++; if (sat_flag[0] !== 1'b1 || m_tvalid[0] !== 1'b1) begin errors++; $display("FAIL mid_pre got s=%b v=%b want 1 1", sat_flag[0], m_tvalid[0]); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (s_tready !== '0) begin errors++; $display("FAIL mid_tready got %b want 000", s_tready); end
      @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (m_tvalid[0] !== 1'b0 || m_tdata[0] !== '0 || sat_flag[0] !== 1'b0) begin errors++; $display("FAIL mid_state got v=%b d=%0d s=%b want 0 0 0", m_tvalid[0], m_tdata[0], sat_flag[0]); end
      m_tready = 1'b1;
      drive(7, 1'b0);
      checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL mid_reprime got %b want 0", m_tvalid[0]); end
      drive(9, 1'b0);
      checks++; if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 16'sd2) begin errors++; $display("FAIL mid_resume got v=%b d=%0d want 1 2", m_tvalid[0], m_tdata[0]); end
      idle(2);
      checks++; if (got_data[0].size() != 2 || got_data[0][1] != 2) begin errors++; $display("FAIL mid_stream got n=%0d want 2 beats ending in 2", got_data[0].size()); end
   endtask

   task automatic test_random();
      reset_all();
      for (int c = 0; c < 600; c++) begin
         s_tvalid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: s_tdata = W'(int'($urandom_range(0, 400)) - 200);
            1: s_tdata = W'($urandom);
            2: s_tdata = 16'sh7fff;
            default: s_tdata = 16'sh8000;
         endcase
         s_tlast  = ($urandom_range(0, 15) == 0);
         m_tready = ($urandom_range(0, 3) != 0);
         rst      = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            checks++; if (s_tready[d] !== (!rst && (!occ[d] || m_tready))) begin errors++; $display("FAIL rnd_tready dut%0d cyc%0d got %b", d, c, s_tready[d]); end
            checks++; if (m_tvalid[d] !== occ[d]) begin errors++; $display("FAIL rnd_tvalid dut%0d cyc%0d got %b want %b", d, c, m_tvalid[d], occ[d]); end
            if (occ[d]) begin
               checks++; if (m_tdata[d] !== W'(pend_data[d]) || m_tlast[d] !== pend_last[d]) begin errors++; $display("FAIL rnd_data dut%0d cyc%0d got %0d/%b want %0d/%b", d, c, m_tdata[d], m_tlast[d], pend_data[d], pend_last[d]); end
            end
            checks++; if (sat_flag[d] !== exp_sat[d]) begin errors++; $display("FAIL rnd_sat dut%0d cyc%0d got %b want %b", d, c, sat_flag[d], exp_sat[d]); end
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
      idle(3);
      for (int d = 0; d < ND; d++) begin
         checks++; if (got_data[d].size() != exp_data[d].size()) begin errors++; $display("FAIL rnd_count dut%0d got %0d want %0d", d, got_data[d].size(), exp_data[d].size()); end
         else for (int i = 0; i < got_data[d].size(); i++) begin
            checks++; if (got_data[d][i] != exp_data[d][i] || got_last[d][i] != exp_last[d][i]) begin errors++; $display("FAIL rnd_stream dut%0d beat%0d got %0d/%b want %0d/%b", d, i, got_data[d][i], got_last[d][i], exp_data[d][i], exp_last[d][i]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
      test_reset();
      test_first_diff();
      test_saturation();
      test_pt5();
      test_backpressure();
      test_frame();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
